// File: rtl/wb_stage_pkg.sv
//------------------------------------------------------------------------------
// Module      : wb_stage_pkg
// Description : Shared core definitions for the WB stage: CSR indices, exception
//               codes, field widths and the MEM->WB bus layout.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_stage_pkg;

  localparam int C_GR_ADDR_WD = 5;
  localparam int C_CSR_NUM_WD = 14;
  localparam int C_ECODE_WD   = 6;
  localparam int C_ESUB_WD    = 9;

  localparam logic [C_CSR_NUM_WD-1:0] C_CSR_CRMD   = 14'h0;
  localparam logic [C_CSR_NUM_WD-1:0] C_CSR_PRMD   = 14'h1;
  localparam logic [C_CSR_NUM_WD-1:0] C_CSR_ESTAT  = 14'h5;
  localparam logic [C_CSR_NUM_WD-1:0] C_CSR_ERA    = 14'h6;
  localparam logic [C_CSR_NUM_WD-1:0] C_CSR_BADV   = 14'h7;
  localparam logic [C_CSR_NUM_WD-1:0] C_CSR_EENTRY = 14'hc;
  localparam logic [C_CSR_NUM_WD-1:0] C_CSR_SAVE0  = 14'h30;
  localparam logic [C_CSR_NUM_WD-1:0] C_CSR_TICLR  = 14'h44;

  localparam logic [C_ECODE_WD-1:0] C_ECODE_ADE = 6'h8;
  localparam logic [C_ECODE_WD-1:0] C_ECODE_ALE = 6'h9;
  localparam logic [C_ECODE_WD-1:0] C_ECODE_SYS = 6'hb;
  localparam logic [C_ECODE_WD-1:0] C_ECODE_BRK = 6'hc;
  localparam logic [C_ECODE_WD-1:0] C_ECODE_INE = 6'hd;

  typedef struct packed {
    logic [31:0]             pc;
    logic                    gr_we;
    logic [C_GR_ADDR_WD-1:0] dest;
    logic [31:0]             final_result;
    logic                    csr_re;
    logic                    csr_we;
    logic [C_CSR_NUM_WD-1:0] csr_num;
    logic [31:0]             csr_wmask;
    logic [31:0]             csr_wvalue;
    logic                    ex;
    logic [C_ECODE_WD-1:0]   ecode;
    logic [C_ESUB_WD-1:0]    esubcode;
    logic [31:0]             badv;
    logic                    ertn;
  } ms_to_ws_bus_t;

  localparam int C_MS_TO_WS_BUS_WD = $bits(ms_to_ws_bus_t);

endpackage

`default_nettype wire

// File: rtl/wb_stage_if.sv
//------------------------------------------------------------------------------
// Module      : wb_stage_if
// Description : MEM->WB handshake and retiring-instruction payload.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface wb_stage_if;
  import wb_stage_pkg::*;

  logic                    ms_to_ws_valid;
  logic                    ws_allowin;
  logic [31:0]             ms_pc;
  logic                    ms_gr_we;
  logic [C_GR_ADDR_WD-1:0] ms_dest;
  logic [31:0]             ms_final_result;
  logic                    ms_csr_re;
  logic                    ms_csr_we;
  logic [C_CSR_NUM_WD-1:0] ms_csr_num;
  logic [31:0]             ms_csr_wmask;
  logic [31:0]             ms_csr_wvalue;
  logic                    ms_ex;
  logic [C_ECODE_WD-1:0]   ms_ecode;
  logic [C_ESUB_WD-1:0]    ms_esubcode;
  logic [31:0]             ms_badv;
  logic                    ms_ertn;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_final_result,
           ms_csr_re, ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
           ms_ex, ms_ecode, ms_esubcode, ms_badv, ms_ertn,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_final_result,
           ms_csr_re, ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue,
           ms_ex, ms_ecode, ms_esubcode, ms_badv, ms_ertn,
    output ws_allowin
  );

endinterface

`default_nettype wire

// File: rtl/wb_stage_trace_gen.sv
//------------------------------------------------------------------------------
// Module      : wb_stage_trace_gen
// Description : Difftest/debug retire trace; active only with DEBUG_TRACE_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_stage_trace_gen
  import wb_stage_pkg::*;
(
  input  wire logic [31:0]             wb_pc,
  input  wire logic                    rf_we,
  input  wire logic [C_GR_ADDR_WD-1:0] rf_waddr,
  input  wire logic [31:0]             rf_wdata,
  output logic [31:0]                  debug_wb_pc,
  output logic [3:0]                   debug_wb_rf_we,
  output logic [C_GR_ADDR_WD-1:0]      debug_wb_rf_wnum,
  output logic [31:0]                  debug_wb_rf_wdata
);

`ifdef DEBUG_TRACE_EN
  assign debug_wb_pc       = wb_pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`else
  // Ports stay so the top-level pinout is identical in both builds.
  logic w_unused_trace;
  assign w_unused_trace    = ^{wb_pc, rf_we, rf_waddr, rf_wdata};
  assign debug_wb_pc       = 32'h0;
  assign debug_wb_rf_we    = 4'h0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = 32'h0;
`endif

endmodule

`default_nettype wire

// File: rtl/wb_stage.sv
//------------------------------------------------------------------------------
// Module      : wb_stage
// Description : Write-back stage: commits GPR/CSR writes, raises exception/ertn
//               flush. Optional trace enabled by macro DEBUG_TRACE_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_stage
  import wb_stage_pkg::*;
(
  input  wire logic                    clk,
  input  wire logic                    reset,
  wb_stage_if.slave                    ms,
  input  wire logic [31:0]             csr_rd_value,
  output logic [C_CSR_NUM_WD-1:0]      csr_num,
  output logic                         csr_we,
  output logic [31:0]                  csr_wmask,
  output logic [31:0]                  csr_wvalue,
  output logic                         wb_ex,
  output logic                         ertn_flush,
  output logic [C_ECODE_WD-1:0]        wb_ecode,
  output logic [C_ESUB_WD-1:0]         wb_esubcode,
  output logic [31:0]                  wb_pc,
  output logic [31:0]                  wb_badv,
  output logic                         ws_flush,
  output logic                         ws_csr_busy,
  output logic                         rf_we,
  output logic [C_GR_ADDR_WD-1:0]      rf_waddr,
  output logic [31:0]                  rf_wdata,
  output logic [31:0]                  debug_wb_pc,
  output logic [3:0]                   debug_wb_rf_we,
  output logic [C_GR_ADDR_WD-1:0]      debug_wb_rf_wnum,
  output logic [31:0]                  debug_wb_rf_wdata
);

  logic          r_ws_valid;
  ms_to_ws_bus_t r_bus;
  ms_to_ws_bus_t w_ms_bus;
  logic          w_ws_ready_go;
  logic          w_ws_allowin;
  logic          w_ws_flush;
  logic          w_capture;

  assign w_ms_bus = '{
    pc:           ms.ms_pc,
    gr_we:        ms.ms_gr_we,
    dest:         ms.ms_dest,
    final_result: ms.ms_final_result,
    csr_re:       ms.ms_csr_re,
    csr_we:       ms.ms_csr_we,
    csr_num:      ms.ms_csr_num,
    csr_wmask:    ms.ms_csr_wmask,
    csr_wvalue:   ms.ms_csr_wvalue,
    ex:           ms.ms_ex,
    ecode:        ms.ms_ecode,
    esubcode:     ms.ms_esubcode,
    badv:         ms.ms_badv,
    ertn:         ms.ms_ertn
  };

  assign w_ws_ready_go = 1'b1;
  assign w_ws_allowin  = ~r_ws_valid | w_ws_ready_go;
  assign ms.ws_allowin = w_ws_allowin;

  // A committing exception/ertn kills whatever MEM offers on the same edge.
  assign w_capture = ms.ms_to_ws_valid & w_ws_allowin & ~w_ws_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ws_valid <= 1'b0;
      r_bus      <= '0;
    end else begin
      if (w_ws_allowin) begin
        r_ws_valid <= w_capture;
      end
      if (w_capture) begin
        r_bus <= w_ms_bus;
      end
    end
  end

  assign wb_ex       = r_ws_valid & r_bus.ex;
  assign ertn_flush  = r_ws_valid & r_bus.ertn & ~r_bus.ex;
  assign w_ws_flush  = wb_ex | ertn_flush;
  assign ws_flush    = w_ws_flush;
  assign ws_csr_busy = r_ws_valid & (r_bus.csr_re | r_bus.csr_we | r_bus.ertn);

  assign csr_we      = r_ws_valid & r_bus.csr_we & ~r_bus.ex;
  assign csr_num     = r_bus.csr_num;
  assign csr_wmask   = r_bus.csr_wmask;
  assign csr_wvalue  = r_bus.csr_wvalue;
  assign wb_ecode    = r_bus.ecode;
  assign wb_esubcode = r_bus.esubcode;
  assign wb_pc       = r_bus.pc;
  assign wb_badv     = r_bus.badv;

  assign rf_we       = r_ws_valid & r_bus.gr_we & ~r_bus.ex;
  assign rf_waddr    = r_bus.dest;
  assign rf_wdata    = r_bus.csr_re ? csr_rd_value : r_bus.final_result;

  wb_stage_trace_gen u_trace_gen (
    .wb_pc             (wb_pc),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_wb_stage
// Description : Directed scoreboard bench for wb_stage (either DEBUG_TRACE_EN build).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_stage;
  import wb_stage_pkg::*;

  typedef struct {
    int          cyc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic        ertn_flush;
    logic        ws_flush;
    logic        csr_busy;
    logic [31:0] wb_pc;
    logic [31:0] wb_badv;
    logic [5:0]  ecode;
    logic [8:0]  esub;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] csr_rd_value;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask, csr_wvalue, wb_pc, wb_badv, rf_wdata;
  logic        wb_ex, ertn_flush, ws_flush, ws_csr_busy, rf_we;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [4:0]  rf_waddr, debug_wb_rf_wnum;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_we;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_miscomp = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  wb_stage_if ms_if ();

  wb_stage u_dut (
    .clk (clk), .reset (reset), .ms (ms_if),
    .csr_rd_value (csr_rd_value), .csr_num (csr_num), .csr_we (csr_we),
    .csr_wmask (csr_wmask), .csr_wvalue (csr_wvalue), .wb_ex (wb_ex),
    .ertn_flush (ertn_flush), .wb_ecode (wb_ecode), .wb_esubcode (wb_esubcode),
    .wb_pc (wb_pc), .wb_badv (wb_badv), .ws_flush (ws_flush),
    .ws_csr_busy (ws_csr_busy), .rf_we (rf_we), .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata), .debug_wb_pc (debug_wb_pc),
    .debug_wb_rf_we (debug_wb_rf_we), .debug_wb_rf_wnum (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Tiny CSR file: SAVE0 holds 0xdeadbeef, everything else reads a tagged index.
  assign csr_rd_value = (csr_num == C_CSR_SAVE0) ? 32'hdeadbeef
                                                 : ({18'h0, csr_num} ^ 32'h5a5a0000);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      n_miscomp++;
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0 && sb_q[0].cyc < cyc) begin
      n_miscomp++;
      $display("FAIL stale_expectation @cyc %0d: got none expected cyc %0d", cyc, sb_q[0].cyc);
      void'(sb_q.pop_front());
    end else if (sb_q.size() != 0 && sb_q[0].cyc == cyc) begin
      mon_e = sb_q.pop_front();
      n_vec++;
      chk("ws_allowin", {31'h0, ms_if.ws_allowin}, 32'h1);
      chk("rf_we", {31'h0, rf_we}, {31'h0, mon_e.rf_we});
      chk("rf_waddr", {27'h0, rf_waddr}, {27'h0, mon_e.rf_waddr});
      chk("rf_wdata", rf_wdata, mon_e.rf_wdata);
      chk("csr_we", {31'h0, csr_we}, {31'h0, mon_e.csr_we});
      chk("csr_num", {18'h0, csr_num}, {18'h0, mon_e.csr_num});
      chk("csr_wmask", csr_wmask, mon_e.csr_wmask);
      chk("csr_wvalue", csr_wvalue, mon_e.csr_wvalue);
      chk("wb_ex", {31'h0, wb_ex}, {31'h0, mon_e.wb_ex});
      chk("ertn_flush", {31'h0, ertn_flush}, {31'h0, mon_e.ertn_flush});
      chk("ws_flush", {31'h0, ws_flush}, {31'h0, mon_e.ws_flush});
      chk("ws_csr_busy", {31'h0, ws_csr_busy}, {31'h0, mon_e.csr_busy});
      chk("wb_pc", wb_pc, mon_e.wb_pc);
      chk("wb_badv", wb_badv, mon_e.wb_badv);
      chk("wb_ecode", {26'h0, wb_ecode}, {26'h0, mon_e.ecode});
      chk("wb_esubcode", {23'h0, wb_esubcode}, {23'h0, mon_e.esub});
`ifdef DEBUG_TRACE_EN
      chk("debug_wb_rf_we", {28'h0, debug_wb_rf_we}, {28'h0, {4{mon_e.rf_we}}});
      chk("debug_wb_rf_wnum", {27'h0, debug_wb_rf_wnum}, {27'h0, mon_e.rf_waddr});
      chk("debug_wb_rf_wdata", debug_wb_rf_wdata, mon_e.rf_wdata);
      chk("debug_wb_pc", debug_wb_pc, mon_e.wb_pc);
`else
      chk("debug_wb_rf_we", {28'h0, debug_wb_rf_we}, 32'h0);
      chk("debug_wb_rf_wnum", {27'h0, debug_wb_rf_wnum}, 32'h0);
      chk("debug_wb_rf_wdata", debug_wb_rf_wdata, 32'h0);
      chk("debug_wb_pc", debug_wb_pc, 32'h0);
`endif
    end
  end

  function automatic exp_t zero_exp();
    exp_t r = '{default: 0};
    return r;
  endfunction

  // WB empty: only the valid-qualified outputs drop, the payload is held.
  function automatic exp_t idle_of(exp_t p);
    exp_t r = p;
    r.rf_we = 1'b0; r.csr_we = 1'b0; r.wb_ex = 1'b0;
    r.ertn_flush = 1'b0; r.ws_flush = 1'b0; r.csr_busy = 1'b0;
    return r;
  endfunction

  task automatic step(input logic rst_v, input logic vld, input ms_to_ws_bus_t m, input exp_t e);
    @(posedge clk);
    #1;
    reset                   = rst_v;
    ms_if.ms_to_ws_valid    = vld;
    ms_if.ms_pc             = m.pc;
    ms_if.ms_gr_we          = m.gr_we;
    ms_if.ms_dest           = m.dest;
    ms_if.ms_final_result   = m.final_result;
    ms_if.ms_csr_re         = m.csr_re;
    ms_if.ms_csr_we         = m.csr_we;
    ms_if.ms_csr_num        = m.csr_num;
    ms_if.ms_csr_wmask      = m.csr_wmask;
    ms_if.ms_csr_wvalue     = m.csr_wvalue;
    ms_if.ms_ex             = m.ex;
    ms_if.ms_ecode          = m.ecode;
    ms_if.ms_esubcode       = m.esubcode;
    ms_if.ms_badv           = m.badv;
    ms_if.ms_ertn           = m.ertn;
    e.cyc = cyc + 1;
    sb_q.push_back(e);
  endtask

  initial begin
    ms_to_ws_bus_t m;
    exp_t          e;
    ms_if.ms_to_ws_valid = 1'b0;

    // reset state, then reset overriding a valid bundle
    m = '0;
    step(1'b1, 1'b0, m, zero_exp());
    m.pc = 32'h1c0000f0; m.gr_we = 1'b1; m.dest = 5'd2; m.final_result = 32'h55;
    step(1'b1, 1'b1, m, zero_exp());

    // plain ALU op
    m = '0; m.pc = 32'h1c000000; m.gr_we = 1'b1; m.dest = 5'd5; m.final_result = 32'h1234;
    e = zero_exp(); e.rf_we = 1'b1; e.rf_waddr = 5'd5; e.rf_wdata = 32'h1234; e.wb_pc = 32'h1c000000;
    step(1'b0, 1'b1, m, e);

    // csrrd of SAVE0, back-to-back
    m = '0; m.pc = 32'h1c000004; m.gr_we = 1'b1; m.dest = 5'd6; m.final_result = 32'h1111;
    m.csr_re = 1'b1; m.csr_num = C_CSR_SAVE0;
    e = zero_exp(); e.rf_we = 1'b1; e.rf_waddr = 5'd6; e.rf_wdata = 32'hdeadbeef;
    e.csr_num = 14'h30; e.csr_busy = 1'b1; e.wb_pc = 32'h1c000004;
    step(1'b0, 1'b1, m, e);

    // csrxchg-style TICLR access: read old value, write masked
    m = '0; m.pc = 32'h1c000008; m.gr_we = 1'b1; m.dest = 5'd7; m.csr_re = 1'b1; m.csr_we = 1'b1;
    m.csr_num = C_CSR_TICLR; m.csr_wmask = 32'hffffffff; m.csr_wvalue = 32'h7;
    e = zero_exp(); e.rf_we = 1'b1; e.rf_waddr = 5'd7; e.rf_wdata = 32'h5a5a0044; e.csr_we = 1'b1;
    e.csr_num = 14'h44; e.csr_wmask = 32'hffffffff; e.csr_wvalue = 32'h7; e.csr_busy = 1'b1;
    e.wb_pc = 32'h1c000008;
    step(1'b0, 1'b1, m, e);

    // ALE exception with gr_we and csr_we both suppressed
    m = '0; m.pc = 32'h1c00000c; m.gr_we = 1'b1; m.dest = 5'd8; m.final_result = 32'habc;
    m.csr_we = 1'b1; m.csr_num = C_CSR_PRMD; m.ex = 1'b1; m.ecode = C_ECODE_ALE;
    m.esubcode = 9'h1; m.badv = 32'h1003;
    e = zero_exp(); e.rf_waddr = 5'd8; e.rf_wdata = 32'habc; e.csr_num = 14'h1;
    e.wb_ex = 1'b1; e.ws_flush = 1'b1; e.csr_busy = 1'b1; e.wb_pc = 32'h1c00000c;
    e.wb_badv = 32'h1003; e.ecode = 6'h9; e.esub = 9'h1;
    step(1'b0, 1'b1, m, e);

    // bundle offered during the exception cycle is dropped
    m = '0; m.pc = 32'h1c000010; m.gr_we = 1'b1; m.dest = 5'd9; m.final_result = 32'h99;
    step(1'b0, 1'b1, m, idle_of(e));

    // ertn together with ex: exception wins
    m = '0; m.pc = 32'h1c000020; m.ertn = 1'b1; m.ex = 1'b1; m.ecode = C_ECODE_SYS;
    e = zero_exp(); e.wb_ex = 1'b1; e.ws_flush = 1'b1; e.csr_busy = 1'b1;
    e.wb_pc = 32'h1c000020; e.ecode = 6'hb;
    step(1'b0, 1'b1, m, e);
    m = '0;
    step(1'b0, 1'b0, m, idle_of(e));

    // ertn alone: one-cycle flush pulse
    m = '0; m.pc = 32'h1c000030; m.ertn = 1'b1;
    e = zero_exp(); e.ertn_flush = 1'b1; e.ws_flush = 1'b1; e.csr_busy = 1'b1; e.wb_pc = 32'h1c000030;
    step(1'b0, 1'b1, m, e);
    m = '0;
    step(1'b0, 1'b0, m, idle_of(e));

    // write to r31 (trace wnum boundary)
    m = '0; m.pc = 32'h1c000040; m.gr_we = 1'b1; m.dest = 5'h1f; m.final_result = 32'hcafef00d;
    e = zero_exp(); e.rf_we = 1'b1; e.rf_waddr = 5'h1f; e.rf_wdata = 32'hcafef00d; e.wb_pc = 32'h1c000040;
    step(1'b0, 1'b1, m, e);

    // csrwr to CRMD, then reset while it sits in WB
    m = '0; m.pc = 32'h1c000044; m.gr_we = 1'b1; m.dest = 5'd4; m.csr_re = 1'b1; m.csr_we = 1'b1;
    m.csr_num = C_CSR_CRMD; m.csr_wmask = 32'h0000ffff; m.csr_wvalue = 32'h3;
    e = zero_exp(); e.rf_we = 1'b1; e.rf_waddr = 5'd4; e.rf_wdata = 32'h5a5a0000; e.csr_we = 1'b1;
    e.csr_wmask = 32'h0000ffff; e.csr_wvalue = 32'h3; e.csr_busy = 1'b1; e.wb_pc = 32'h1c000044;
    step(1'b0, 1'b1, m, e);
    m = '0; m.pc = 32'h1c000048; m.gr_we = 1'b1; m.dest = 5'd10; m.final_result = 32'ha;
    step(1'b1, 1'b1, m, zero_exp());
    m = '0;
    step(1'b0, 1'b0, m, zero_exp());

    // resume after reset, then drain
    m = '0; m.pc = 32'h1c000050; m.gr_we = 1'b1; m.dest = 5'd3; m.final_result = 32'h33;
    e = zero_exp(); e.rf_we = 1'b1; e.rf_waddr = 5'd3; e.rf_wdata = 32'h33; e.wb_pc = 32'h1c000050;
    step(1'b0, 1'b1, m, e);
    m = '0;
    step(1'b0, 1'b0, m, idle_of(e));

    repeat (20) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      n_miscomp++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_stage.md
# wb_stage

Write-back pipeline stage of the five-stage LoongArch core, directly upstream of the CSR control block. It latches the retiring instruction from the MEM stage through the valid/allowin handshake. It commits the register-file write, drives the CSR read/write/exception/ertn signals that the CSR block consumes, and raises the pipeline flush. Optionally it emits the difftest/debug trace.

## Interface
Parameters: none. Widths come from the shared package.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- ms_to_ws_valid  in  1  MEM holds a valid instruction
- ws_allowin  out  1  WB can accept this cycle
- ms_pc  in  32  instruction PC
- ms_gr_we  in  1  GPR write request
- ms_dest  in  5  GPR destination
- ms_final_result  in  32  ALU/load result
- ms_csr_re  in  1  result comes from CSR read
- ms_csr_we  in  1  CSR write request
- ms_csr_num  in  14  CSR index
- ms_csr_wmask  in  32  CSR write mask
- ms_csr_wvalue  in  32  CSR write value
- ms_ex  in  1  exception tagged on this instruction
- ms_ecode  in  6  exception code
- ms_esubcode  in  9  exception subcode
- ms_badv  in  32  faulting data address
- ms_ertn  in  1  instruction is ertn
- csr_rd_value  in  32  combinational CSR read data, indexed by csr_num
- csr_num  out  14  CSR index to CSR block
- csr_we  out  1  CSR write commit
- csr_wmask  out  32  CSR write mask
- csr_wvalue  out  32  CSR write value
- wb_ex  out  1  exception commit
- ertn_flush  out  1  ertn commit
- wb_ecode  out  6  exception code
- wb_esubcode  out  9  exception subcode
- wb_pc  out  32  PC for ERA/BADV
- wb_badv  out  32  BADV candidate
- ws_flush  out  1  kill IF/ID/EXE/MEM (= wb_ex | ertn_flush)
- ws_csr_busy  out  1  valid CSR-touching or ertn instruction in WB (ID hazard)
- rf_we  out  1  GPR write enable (also the forwarding valid)
- rf_waddr  out  5  GPR address
- rf_wdata  out  32  GPR data
- debug_wb_pc, debug_wb_rf_we[3:0], debug_wb_rf_wnum[4:0], debug_wb_rf_wdata[31:0]  out  trace (see Configuration)

## Operation
- Holds one state register ws_valid plus the latched payload registers (all ms_* fields).
- ws_ready_go = 1. ws_allowin = ~ws_valid | ws_ready_go.
- Capture: when ms_to_ws_valid & ws_allowin & ~ws_flush, ws_valid <= 1 and the payload is loaded. Otherwise, when ws_allowin, ws_valid <= 0.
- Flush: when ws_flush = 1, ws_valid <= 0 at the next edge, and the incoming MEM bundle is discarded on that same edge.
- wb_ex = ws_valid & ex. ertn_flush = ws_valid & ertn & ~ex.
- csr_we = ws_valid & csr_we_r & ~ex. rf_we = ws_valid & gr_we_r & ~ex.
- rf_wdata = csr_re_r ? csr_rd_value : final_result_r.
- csr_num, wmask, wvalue, ecode, esubcode, pc and badv are driven from the payload registers unconditionally. The CSR block qualifies them with we/ex.
- ws_csr_busy = ws_valid & (csr_re_r | csr_we_r | ertn_r).

## Timing
- Reset: ws_valid = 0 and every payload register = 0. All outputs are therefore 0, ws_allowin = 1.
- Latency MEM→WB is one cycle. All commit outputs are combinational from the WB registers. The CSR/GPR state updates at the following posedge.
- The CSR read is same-cycle: csr_num → csr_rd_value → rf_wdata within the WB cycle.
- Simultaneous ex and ertn: ex wins, and ertn_flush stays 0.
- Simultaneous ex and csr_we/gr_we: the writes are suppressed.
- Reset asserted mid-operation overrides capture and flush.
- Back-to-back instructions retire one per cycle, with no bubble.

## Configuration
- DEBUG_TRACE_EN defined: debug_wb_pc = wb_pc, debug_wb_rf_we = {4{rf_we}}, debug_wb_rf_wnum = rf_waddr, debug_wb_rf_wdata = rf_wdata.
- DEBUG_TRACE_EN undefined: debug ports remain present and are tied to 0.

## Structure
- Shared package (mycpu.h): CSR index constants (CRMD 0x0, ERA 0x6, BADV 0x7, TICLR 0x44, ...), ECODE constants (ADE 0x8, ALE 0x9, SYS 0xB, BRK 0xC, INE 0xD), and the MEM→WB bus width.
- One natural sub-module is wb_trace_gen, containing the DEBUG_TRACE_EN trace mapping.

## Test plan
- Plain ALU op: pc 0x1c000000, gr_we = 1, dest 5, result 0x1234 → next cycle rf_we = 1, rf_waddr = 5, rf_wdata = 0x1234, with no flush.
- csrrd: csr_re = 1, csr_num = 0x30, csr_rd_value = 0xdeadbeef → rf_wdata = 0xdeadbeef, csr_we = 0, ws_csr_busy = 1.
- Exception: ex = 1, ecode 0x9, badv 0x1003, gr_we = 1, csr_we = 1 → wb_ex = 1, ws_flush = 1, rf_we = 0, csr_we = 0, wb_badv = 0x1003. The MEM bundle presented the same cycle is dropped, and ws_valid = 0 on the next cycle.
- ertn with ex = 1 → wb_ex = 1, ertn_flush = 0. ertn alone → ertn_flush = 1 for exactly one cycle.
- Reset is asserted while a valid csrwr sits in WB → all outputs are 0 on the next cycle and no csr_we pulse occurs.
- DEBUG_TRACE_EN build: a gr_we to dest 0x1f gives debug_wb_rf_we = 4'hf and debug_wb_rf_wnum = 0x1f. Non-define build: the debug ports read 0.
